fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_sequencer_if.sv | 42 ++++
 rtl/fetch_skid_fifo.sv | 51 +++++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, state encoding and buffer entry for the fetch sequencer
package fetch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory, redirect, decode and fault signals of the fetch sequencer
interface fetch_sequencer_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] mem_pc;
    logic [XLEN-1:0] mem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            fault;
    logic [XLEN-1:0] fault_pc;

    modport master (
        output mem_pc,
        input  mem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        output fault,
        output fault_pc
    );

    modport slave (
        input  mem_pc,
        output mem_instr,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        input  fault,
        input  fault_pc
    );

endinterface

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - two-entry in-order instruction buffer with flush
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_en,
    input  fetch_entry_t wr_data,
    input  logic         rd_en,
    output fetch_entry_t rd_data,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Entry storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy; a flush empties the buffer regardless of traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(wr_en) - 2'(rd_en);
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer; FETCH_SEQ_ALIGN_CHECK_EN enables misaligned-redirect halting
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024
)(
    input  logic             clk,
    input  logic             rst,
    fetch_sequencer_if.master bus
);

    localparam logic [0:0]      ST_RUN    = RUN;
    localparam logic [0:0]      ST_HALT   = HALT;
    localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(MEM_BYTES - 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tag_q;
    logic            inflight_q;
    logic [0:0]      state_q;

    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;
    logic            pop;
    logic            issue;
    logic [2:0]      occupancy;
    logic            misaligned;
    logic [XLEN-1:0] target_pc;

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
    assign target_pc  = bus.redirect_pc;
`else
    assign misaligned = 1'b0;
    assign target_pc  = bus.redirect_pc & ~XLEN'(3);
`endif

    // Slots already committed (buffered plus outstanding) after this cycle's transfer.
    assign pop       = bus.inst_valid && bus.inst_ready;
    assign occupancy = 3'(count) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == ST_RUN) && !bus.redirect_valid && (occupancy < 3'd2);

    assign wr_entry.instr = bus.mem_instr;
    assign wr_entry.pc    = tag_q;

    fetch_skid_fifo u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.redirect_valid),
        .wr_en   (inflight_q && !bus.redirect_valid),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    // Fetch pointer, outstanding-read tag and run/halt state; redirect outranks issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            state_q    <= ST_RUN;
        end else if (bus.redirect_valid) begin
            inflight_q <= 1'b0;
            if (misaligned) begin
                state_q <= ST_HALT;
            end else begin
                state_q <= ST_RUN;
                pc_q    <= target_pc;
            end
        end else if (issue) begin
            pc_q       <= pc_q + XLEN'(4);
            tag_q      <= pc_q;
            inflight_q <= 1'b1;
        end else begin
            inflight_q <= 1'b0;
        end
    end

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    logic            fault_q;
    logic [XLEN-1:0] fault_pc_q;

    // Fault report tracks the most recent redirect: set on misaligned, cleared on aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (bus.redirect_valid) begin
            fault_q    <= misaligned;
            fault_pc_q <= misaligned ? bus.redirect_pc : '0;
        end
    end

    assign bus.fault    = fault_q;
    assign bus.fault_pc = fault_pc_q;
`else
    assign bus.fault    = 1'b0;
    assign bus.fault_pc = '0;
`endif

    assign bus.mem_pc     = pc_q & ADDR_MASK;
    assign bus.inst_valid = (count != 2'd0);
    assign bus.inst_data  = head.instr;
    assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - bench for fetch_sequencer, follows FETCH_SEQ_ALIGN_CHECK_EN when defined
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Registered instruction memory: word i holds 0x1000 + i.
    always @(posedge clk) begin
        bus.mem_instr <= 32'h1000 + {22'd0, bus.mem_pc[9:2]};
    end

    // Reference model: a queue of fetched addresses, each visible from its arrival cycle.
    typedef struct {
        logic [31:0] pc;
        int          arr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] npc;
    bit          halted;
    bit          mfault;
    logic [31:0] mfault_pc;
    int          now;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000 + ((pc & 32'(MEM_BYTES - 1)) >> 2);
    endfunction

    function automatic bit model_valid();
        return (mq.size() > 0) && (mq[0].arr <= now);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, now);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        npc       = RESET_PC;
        halted    = 1'b0;
        mfault    = 1'b0;
        mfault_pc = 32'h0;
        now       = 0;
    endtask

    task automatic model_check();
        bit v;
        v = model_valid();
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, v});
        if (v) begin
            chk("inst_pc", bus.inst_pc, mq[0].pc);
            chk("inst_data", bus.inst_data, word_at(mq[0].pc));
        end
        chk("mem_pc", bus.mem_pc, npc & 32'(MEM_BYTES - 1));
        chk("fault", {31'd0, bus.fault}, {31'd0, mfault});
        chk("fault_pc", bus.fault_pc, mfault_pc);
    endtask

    // One cycle: check outputs, drive inputs, advance the model, move to the next edge.
    task automatic cycle(input bit ready, input bit rv, input logic [31:0] rpc);
        bit pop;
        model_check();
        bus.inst_ready     = ready;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        pop = model_valid() && ready;
        if (pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) begin
                halted    = 1'b1;
                mfault    = 1'b1;
                mfault_pc = rpc;
            end else begin
                halted    = 1'b0;
                mfault    = 1'b0;
                mfault_pc = 32'h0;
                npc       = rpc;
            end
`else
            npc = {rpc[31:2], 2'b00};
`endif
        end else if (!halted && mq.size() < 2) begin
            mq.push_back('{npc, now + 2});
            npc = npc + 32'd4;
        end
        now++;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_fault", {31'd0, bus.fault}, 32'd0);
        chk("rst_fault_pc", bus.fault_pc, 32'd0);
        chk("rst_mem_pc", bus.mem_pc, RESET_PC & 32'(MEM_BYTES - 1));
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", {31'd0, bus.inst_valid}, 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] rpc;
        rst                = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Startup latency, then a five-cycle stall from cycle 3.
        for (int c = 0; c <= 10; c++) begin
            if (c == 2) begin
                chk("start_valid", {31'd0, bus.inst_valid}, 32'd1);
                chk("start_pc", bus.inst_pc, 32'h0);
                chk("start_data", bus.inst_data, 32'h1000);
            end
            if (c == 7) begin
                chk("stall_pc", bus.inst_pc, 32'h4);
                chk("stall_mem_pc", bus.mem_pc, 32'hC);
            end
            if (c == 9)  chk("resume_pc8", bus.inst_pc, 32'h8);
            if (c == 10) chk("resume_pcC", bus.inst_pc, 32'hC);
            cycle(!(c >= 3 && c <= 7), 1'b0, 32'h0);
        end

        // Redirect to 0x40 in cycle 6.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            if (c == 7 || c == 8) chk("redir_gap", {31'd0, bus.inst_valid}, 32'd0);
            if (c == 9) begin
                chk("redir_valid", {31'd0, bus.inst_valid}, 32'd1);
                chk("redir_pc40", bus.inst_pc, 32'h40);
            end
            if (c == 10) chk("redir_pc44", bus.inst_pc, 32'h44);
            cycle(1'b1, c == 6, 32'h40);
        end

        // Address wrap at the top of the 32-bit space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_mem_pc", bus.mem_pc, 32'h3FC);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_mem_pc0", bus.mem_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_pc_top", bus.inst_pc, 32'hFFFF_FFFC);
        chk("wrap_data_top", bus.inst_data, 32'h10FF);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_pc_zero", bus.inst_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);

        // Misaligned redirect target.
        cycle(1'b1, 1'b1, 32'h42);
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        chk("mis_fault", {31'd0, bus.fault}, 32'd1);
        chk("mis_fault_pc", bus.fault_pc, 32'h42);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
        cycle(1'b1, 1'b1, 32'h80);
        chk("unhalt_fault", {31'd0, bus.fault}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("unhalt_pc80", bus.inst_pc, 32'h80);
`else
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("mis_masked_pc", bus.inst_pc, 32'h40);
        chk("mis_no_fault", {31'd0, bus.fault}, 32'd0);
`endif
        cycle(1'b1, 1'b0, 32'h0);

        // Randomized traffic: backpressure, redirects (including back-to-back), odd targets.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 8)
                0:       rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                1:       rpc = $urandom;
                default: rpc = 32'(4 * $urandom_range(0, 255));
            endcase
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, rpc);
        end

        // Fill the buffer, then pulse reset asynchronously.
        cycle(1'b1, 1'b1, 32'h100);
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 32'h0);
        chk("full_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("full_pc", bus.inst_pc, 32'h100);
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            if (c == 2) chk("restart_pc", bus.inst_pc, RESET_PC);
            cycle(1'b1, 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
